// File: rtl/nearest_avg_window_if.sv
// Sample/result bus for nearest_avg_window: the source side drives samples and
// control, the engine side returns window status and results.
interface nearest_avg_window_if #(
  parameter int DW = 16
);
  logic          din_valid;
  logic [DW-1:0] din;
  logic          mode;
  logic          flush;
  logic          ready;
  logic          dout_valid;
  logic [DW-1:0] dout;

  modport master (
    output din_valid, din, mode, flush,
    input  ready, dout_valid, dout
  );

  modport slave (
    input  din_valid, din, mode, flush,
    output ready, dout_valid, dout
  );
endinterface

// File: rtl/nearest_avg_window.sv
// Sliding-window statistic: emits the window sample nearest the average, or the average.
// Define NAVG_ROUND_EN for a round-half-up average instead of a truncating one.
module nearest_avg_window #(
  parameter int DW    = 16,
  parameter int DEPTH = 12
) (
  input  logic               clk,
  input  logic               reset,
  nearest_avg_window_if.slave bus
);

  localparam int SW = DW + $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {FILL, RUN} state_t;

  logic [DW-1:0] window_reg [DEPTH];
  state_t        state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic          pending_reg, pending_next;
  logic          dout_valid_reg;
  logic [DW-1:0] dout_reg;

  logic [SW-1:0] sum;
  logic [DW-1:0] avg;
  logic [DW-1:0] diff [DEPTH];
  logic [DW-1:0] nearest;
  logic [DW-1:0] best_diff;
  logic          result_en;

  // Contents are meaningful only up to count_reg, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (bus.din_valid) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        window_reg[i] <= window_reg[i + 1];
      end
      window_reg[DEPTH - 1] <= bus.din;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sum = sum + SW'(window_reg[i]);
    end
  end

`ifdef NAVG_ROUND_EN
  assign avg = DW'((sum + SW'(DEPTH / 2)) / SW'(DEPTH));
`else
  assign avg = DW'(sum / SW'(DEPTH));
`endif

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_diff
    assign diff[gi] = (window_reg[gi] >= avg) ? (window_reg[gi] - avg)
                                              : (avg - window_reg[gi]);
  end

  // Equal distances resolve toward the smaller sample value.
  always_comb begin
    nearest   = window_reg[0];
    best_diff = diff[0];
    for (int i = 1; i < DEPTH; i++) begin
      if ((diff[i] < best_diff) ||
          ((diff[i] == best_diff) && (window_reg[i] < nearest))) begin
        nearest   = window_reg[i];
        best_diff = diff[i];
      end
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pending_next = 1'b0;
    if (bus.flush) begin
      // A sample arriving with flush becomes the first sample of the new fill.
      state_next = FILL;
      count_next = CW'(bus.din_valid);
    end else if (bus.din_valid) begin
      if (state_reg == FILL) begin
        count_next = count_reg + CW'(1);
        if (count_next == CW'(DEPTH)) begin
          state_next = RUN;
        end
      end
      pending_next = (state_next == RUN);
    end
  end

  assign result_en = pending_reg & ~bus.flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FILL;
      count_reg      <= '0;
      pending_reg    <= 1'b0;
      dout_valid_reg <= 1'b0;
      dout_reg       <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      pending_reg    <= pending_next;
      dout_valid_reg <= result_en;
      if (result_en) begin
        dout_reg <= bus.mode ? avg : nearest;
      end
    end
  end

  assign bus.ready      = (state_reg == RUN);
  assign bus.dout_valid = dout_valid_reg;
  assign bus.dout       = dout_reg;

endmodule

// File: tb/tb_nearest_avg_window.sv
// Directed bench for nearest_avg_window (DW=16, DEPTH=12) with hand-computed results.
module tb_nearest_avg_window;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

`ifdef NAVG_ROUND_EN
  localparam logic [15:0] E_FIRST  = 16'd7;
  localparam logic [15:0] E_SECOND = 16'd8;
  localparam logic [15:0] E_GAP1   = 16'hEAAA;
  localparam logic [15:0] E_GAP2   = 16'hD555;
`else
  localparam logic [15:0] E_FIRST  = 16'd6;
  localparam logic [15:0] E_SECOND = 16'd7;
  localparam logic [15:0] E_GAP1   = 16'hEAA9;
  localparam logic [15:0] E_GAP2   = 16'hD554;
`endif

  nearest_avg_window_if #(.DW(16)) bus ();

  nearest_avg_window #(.DW(16), .DEPTH(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] d, input logic m, input logic f);
    @(negedge clk);
    reset         = 1'b0;
    bus.din_valid = v;
    bus.din       = d;
    bus.mode      = m;
    bus.flush     = f;
    @(posedge clk);
    #1;
    $display("step v=%0b din=%0h mode=%0b flush=%0b -> ready=%0b dout_valid=%0b dout=%0h",
             v, d, m, f, bus.ready, bus.dout_valid, bus.dout);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.mode      = 1'b0;
    bus.din       = '0;
    @(posedge clk);
    #1;
    $display("reset -> ready=%0b dout_valid=%0b dout=%0h", bus.ready, bus.dout_valid, bus.dout);
  endtask

  initial begin
    reset         = 1'b1;
    bus.din_valid = 1'b0;
    bus.din       = '0;
    bus.mode      = 1'b0;
    bus.flush     = 1'b0;

    do_reset();
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_dv", 32'(bus.dout_valid), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);

    // Ramp fill 1..12, then 13 back-to-back.
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 16'(i), 1'b0, 1'b0);
      check("fill_ready", 32'(bus.ready), 32'(i == 12));
      check("fill_dv", 32'(bus.dout_valid), 32'd0);
    end
    step(1'b1, 16'd13, 1'b0, 1'b0);
    check("ramp1_dv", 32'(bus.dout_valid), 32'd1);
    check("ramp1_dout", 32'(bus.dout), 32'(E_FIRST));
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("ramp2_dv", 32'(bus.dout_valid), 32'd1);
    check("ramp2_dout", 32'(bus.dout), 32'(E_SECOND));
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("idle_dv", 32'(bus.dout_valid), 32'd0);
    check("idle_hold", 32'(bus.dout), 32'(E_SECOND));

    // Same ramp after a mid-run reset, average mode.
    do_reset();
    check("rst2_ready", 32'(bus.ready), 32'd0);
    check("rst2_dout", 32'(bus.dout), 32'd0);
    for (int i = 1; i <= 13; i++) step(1'b1, 16'(i), 1'b0, 1'b0);
    step(1'b0, 16'd0, 1'b1, 1'b0);
    check("ramp_avg_dv", 32'(bus.dout_valid), 32'd1);
    check("ramp_avg_dout", 32'(bus.dout), 32'(E_SECOND));

    // Tie: six 8s and six 12s, average 10, every distance 2.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, (i % 2 == 0) ? 16'd8 : 16'd12, 1'b0, 1'b0);
    step(1'b1, 16'd8, 1'b0, 1'b0);
    check("tie_near_dv", 32'(bus.dout_valid), 32'd1);
    check("tie_near_dout", 32'(bus.dout), 32'd8);
    step(1'b0, 16'd0, 1'b1, 1'b0);
    check("tie_avg_dout", 32'(bus.dout), 32'd10);

    // Full scale in both modes.
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("full_avg_dout", 32'(bus.dout), 32'h0000FFFF);
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("full_near_dv", 32'(bus.dout_valid), 32'd1);
    check("full_near_dout", 32'(bus.dout), 32'h0000FFFF);

    // Gapped input; din changes while invalid must be ignored.
    step(1'b1, 16'd0, 1'b1, 1'b0);
    check("gap_acc_dv", 32'(bus.dout_valid), 32'd0);
    step(1'b0, 16'd5, 1'b1, 1'b0);
    check("gap1_dv", 32'(bus.dout_valid), 32'd1);
    check("gap1_dout", 32'(bus.dout), 32'(E_GAP1));
    step(1'b0, 16'd7, 1'b1, 1'b0);
    check("gap_idle_dv", 32'(bus.dout_valid), 32'd0);
    check("gap_idle_hold", 32'(bus.dout), 32'(E_GAP1));
    step(1'b1, 16'd0, 1'b1, 1'b0);
    step(1'b0, 16'd9, 1'b1, 1'b0);
    check("gap2_dv", 32'(bus.dout_valid), 32'd1);
    check("gap2_dout", 32'(bus.dout), 32'(E_GAP2));

    // Flush with a sample while a result is pending.
    step(1'b1, 16'd0, 1'b0, 1'b0);
    step(1'b1, 16'd3, 1'b0, 1'b1);
    check("flush_ready", 32'(bus.ready), 32'd0);
    check("flush_dv", 32'(bus.dout_valid), 32'd0);
    check("flush_hold", 32'(bus.dout), 32'(E_GAP2));
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("flush_next_dv", 32'(bus.dout_valid), 32'd0);
    for (int i = 1; i <= 11; i++) begin
      step(1'b1, 16'd20, 1'b0, 1'b0);
      check("refill_ready", 32'(bus.ready), 32'(i == 11));
    end
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("refill_dv", 32'(bus.dout_valid), 32'd1);
    check("refill_dout", 32'(bus.dout), 32'd20);

    // Flush in RUN without a sample, then reset mid-fill.
    step(1'b0, 16'd0, 1'b0, 1'b1);
    check("flush2_ready", 32'(bus.ready), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'd4, 1'b0, 1'b0);
    do_reset();
    check("midfill_ready", 32'(bus.ready), 32'd0);
    check("midfill_dv", 32'(bus.dout_valid), 32'd0);
    check("midfill_dout", 32'(bus.dout), 32'd0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 16'd4, 1'b0, 1'b0);
      check("restart_ready", 32'(bus.ready), 32'(i == 12));
    end
    step(1'b0, 16'd0, 1'b0, 1'b0);
    check("restart_dout", 32'(bus.dout), 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nearest_avg_window.md
Name: nearest_avg_window

Overview:
- Parametrised sliding-window statistic engine for DW-bit sample streams; generalises the fixed 12-sample nearest-to-average filter.
- Holds the last DEPTH accepted samples, computes the window average and emits either the window sample closest to it or the average itself.
- Adds a per-sample valid qualifier, a result valid strobe, a runtime mode and a flush.
- Sits between a sample source and downstream filtering/decision logic.

Parameters:
DW, 16, sample and result width in bits (>=2)
DEPTH, 12, window length in samples (2..64)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
din_valid  input  1  din accepted on this edge when high
din  input  DW  unsigned sample
mode  input  1  0 = nearest-to-average sample, 1 = average value; sampled on the same edge as the result register
flush  input  1  discard window contents, restart fill
ready  output  1  level; high while window holds DEPTH samples
dout_valid  output  1  one-cycle pulse per produced result
dout  output  DW  result; holds last value between pulses

Behaviour:
- Interface fixed: single clock clk; reset is synchronous and active-high.
- Reset: ready=0, dout_valid=0, dout=0, fill count=0, window contents don't-care. Mid-operation reset discards everything; the first valid after reset is sample 1 of a new fill.
- Window: shift register, oldest at index 0, newest at DEPTH-1. On each edge with din_valid=1, shift by one and insert din at the newest slot. Fill count saturates at DEPTH.
- States: FILL (count<DEPTH) and RUN (count==DEPTH). ready=1 exactly in RUN.
  - FILL->RUN on the edge that accepts the DEPTH-th sample.
  - RUN->FILL only on flush or reset.
- Result timing: an edge that accepts a sample and leaves the window full marks a result pending. The next edge registers dout from the updated window and pulses dout_valid for one cycle.
  - Latency is 1 cycle after the accepting edge.
  - Back-to-back valids produce one result per cycle.
  - No result is produced without a new sample.
- Arithmetic:
  - sum width DW+clog2(DEPTH) bits, no overflow possible.
  - avg = floor(sum/DEPTH), always fits DW.
  - diff_i = |window_i - avg|, unsigned.
- Mode 0: dout = window_i with minimum diff_i.
  - Tie on diff: the smaller value wins.
  - Tie on diff and value: the outputs are identical.
- Mode 1: dout = avg.
- Flush: clears count to 0, forces FILL, cancels any pending result (no dout_valid the following cycle); dout holds.
  - Flush and din_valid on the same edge: flush wins the clear, and din is accepted as sample 1 (count=1).
  - Flush while in FILL: same behaviour.
- din is ignored when din_valid=0. Window, count and dout hold.

Optional Feature:
- Macro NAVG_ROUND_EN.
- Defined: avg = floor((sum + DEPTH/2)/DEPTH), i.e. round-half-up. This applies to both modes and to diff computation.
- Undefined: truncating average as above. Port list and timing are identical either way.

Test Plan:
- Reset, then 1..12 with din_valid each cycle, mode=0. Required response:
  - ready rises on the edge accepting 12.
  - Next cycle dout_valid=1, dout=6 (sum 78, avg 6).
  - With NAVG_ROUND_EN: dout=7.
- Continue with 13, mode=0. Required response:
  - Window 2..13, sum 90, avg 7, dout=7.
  - With NAVG_ROUND_EN: avg 8, dout=8.
  - mode=1 on the same stream gives dout=7 (8 with NAVG_ROUND_EN).
- Tie case: fill with six 8s interleaved with six 12s, mode=0. Required response: avg 10, all diffs 2, dout=8.
- Full scale: fill with twelve 0xFFFF, both modes. Required response: dout=0xFFFF, no wrap.
- Gapped input: din_valid toggles 1/0. Required response:
  - dout_valid pulses only one cycle after each accepting edge in RUN.
  - dout holds between pulses.
  - Changing din while din_valid=0 has no effect.
- Flush with din_valid on the same edge while in RUN. Required response:
  - ready=0 next cycle, and no dout_valid.
  - Eleven more samples are needed before ready=1.
  - Reset asserted mid-fill restarts the count from 0, with dout=0.
